// File: rtl/reorder_buffer.sv
// -----------------------------------------------------------------------------
// reorder_buffer
//
// In-order retirement buffer that sits between dispatch and the register file.
// Each dispatched instruction gets a tag (1..ROB_SIZE, tag 0 means "no
// producer"). Results broadcast on the CDB are captured into the matching
// entry. The oldest completed entry retires each cycle. If a retiring branch
// was mispredicted, the buffer flushes and issues a one-cycle rollback.
// Dispatch can query operand tags to forward results that have completed but
// not yet retired.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   dec_*_in              dispatch request and the instruction's fields
//   rob_next_tag_out      tag the current dispatch receives (= tail)
//   rob_full_out          buffer holds ROB_SIZE entries
//   cdb_*_in              result broadcast (tag, value, branch outcome)
//   q1/q2_tag_in          operand tags to look up
//   q1/q2_ready/data_out  lookup result (includes same-cycle CDB bypass)
//   commit_*_out          registered retire pulse and the retired fields
//   rollback_out/_pc_out  registered flush pulse and redirect PC
// -----------------------------------------------------------------------------
module reorder_buffer #(
  parameter int ROB_SIZE = 15,
  parameter int TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  // dispatch
  input  logic             dec_valid_in,
  input  logic             dec_has_rd_in,
  input  logic [4:0]       dec_rd_in,
  input  logic [31:0]      dec_pc_in,
  input  logic             dec_is_branch_in,
  input  logic             dec_pred_taken_in,
  output logic [TAG_W-1:0] rob_next_tag_out,
  output logic             rob_full_out,
  // common data bus
  input  logic             cdb_valid_in,
  input  logic [TAG_W-1:0] cdb_tag_in,
  input  logic [31:0]      cdb_data_in,
  input  logic             cdb_taken_in,
  input  logic [31:0]      cdb_target_in,
  // operand queries
  input  logic [TAG_W-1:0] q1_tag_in,
  input  logic [TAG_W-1:0] q2_tag_in,
  output logic             q1_ready_out,
  output logic             q2_ready_out,
  output logic [31:0]      q1_data_out,
  output logic [31:0]      q2_data_out,
  // commit
  output logic             commit_signal_out,
  output logic             commit_rf_signal_out,
  output logic [31:0]      commit_pc_out,
  output logic [TAG_W-1:0] commit_tag_out,
  output logic [31:0]      commit_data_out,
  output logic [4:0]       commit_target_out,
  // rollback
  output logic             rollback_out,
  output logic [31:0]      rollback_pc_out
);

  localparam int CNT_W = $clog2(ROB_SIZE + 1);
  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(ROB_SIZE);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  // Per-entry control bits, indexed directly by tag.
  logic [ROB_SIZE:1] r_busy;
  logic [ROB_SIZE:1] r_ready;
  logic [ROB_SIZE:1] r_has_rd;
  logic [ROB_SIZE:1] r_is_branch;
  logic [ROB_SIZE:1] r_pred;
  logic [ROB_SIZE:1] r_taken;

  // Per-entry payload; only meaningful while busy, so it carries no reset.
  logic [4:0]  r_rd     [1:ROB_SIZE];
  logic [31:0] r_pc     [1:ROB_SIZE];
  logic [31:0] r_target [1:ROB_SIZE];
  logic [31:0] r_data   [1:ROB_SIZE];

  // Registered outputs
  logic             r_commit;
  logic             r_commit_rf;
  logic [31:0]      r_commit_pc;
  logic [TAG_W-1:0] r_commit_tag;
  logic [31:0]      r_commit_data;
  logic [4:0]       r_commit_rd;
  logic             r_rollback;
  logic [31:0]      r_rollback_pc;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  logic w_full;
  logic w_dispatch;
  logic w_cdb_hit;
  logic w_commit;
  logic w_mispredict;

  function automatic logic [TAG_W-1:0] f_next_ptr(input logic [TAG_W-1:0] ptr);
    return (ptr == LAST_TAG) ? FIRST_TAG : ptr + FIRST_TAG;
  endfunction

  // Full is taken from the registered count, so a commit on the same edge
  // cannot make room for a dispatch in that cycle.
  assign w_full = (r_count == FULL_CNT);

  // While the rollback pulse is high the front end is still delivering
  // wrong-path instructions and results, so both are dropped.
  assign w_dispatch = dec_valid_in && !w_full && !r_rollback;

  assign w_cdb_hit = cdb_valid_in && (cdb_tag_in != '0) && !r_rollback &&
                     r_busy[cdb_tag_in];

  assign w_commit = r_busy[r_head] && r_ready[r_head];

  assign w_mispredict = w_commit && r_is_branch[r_head] &&
                        (r_taken[r_head] != r_pred[r_head]);

  // One-hot per-entry strobes for allocate, capture and retire.
  logic [ROB_SIZE:1] w_alloc;
  logic [ROB_SIZE:1] w_capture;
  logic [ROB_SIZE:1] w_retire;

  genvar gi;
  generate
    for (gi = 1; gi <= ROB_SIZE; gi++) begin : g_entry_strobe
      assign w_alloc[gi]   = w_dispatch && (r_tail == TAG_W'(gi));
      assign w_capture[gi] = w_cdb_hit && (cdb_tag_in == TAG_W'(gi));
      assign w_retire[gi]  = w_commit && (r_head == TAG_W'(gi));
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Pointers, count and per-entry control bits
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= FIRST_TAG;
      r_tail  <= FIRST_TAG;
      r_count <= '0;
      r_busy  <= '0;
      r_ready <= '0;
    end else if (w_mispredict) begin
      // Everything younger than the branch is on the wrong path: empty the
      // buffer. A dispatch or capture on this edge is discarded with it.
      r_head  <= FIRST_TAG;
      r_tail  <= FIRST_TAG;
      r_count <= '0;
      r_busy  <= '0;
      r_ready <= '0;
    end else begin
      // Allocation only targets a non-busy tail slot and capture only a busy
      // slot, so the two strobes never hit the same entry.
      r_busy  <= (r_busy | w_alloc) & ~w_retire;
      r_ready <= ((r_ready & ~w_alloc) | w_capture) & ~w_retire;

      if (w_commit) begin
        r_head <= f_next_ptr(r_head);
      end
      if (w_dispatch) begin
        r_tail <= f_next_ptr(r_tail);
      end

      unique case ({w_dispatch, w_commit})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Entry payload
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 1; i <= ROB_SIZE; i++) begin
      if (w_alloc[i]) begin
        r_has_rd[i]    <= dec_has_rd_in;
        r_rd[i]        <= dec_rd_in;
        r_pc[i]        <= dec_pc_in;
        r_is_branch[i] <= dec_is_branch_in;
        r_pred[i]      <= dec_pred_taken_in;
      end
      if (w_capture[i]) begin
        r_data[i]   <= cdb_data_in;
        r_taken[i]  <= cdb_taken_in;
        r_target[i] <= cdb_target_in;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Commit and rollback outputs: single-cycle pulses, zero when idle
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_commit      <= 1'b0;
      r_commit_rf   <= 1'b0;
      r_commit_pc   <= '0;
      r_commit_tag  <= '0;
      r_commit_data <= '0;
      r_commit_rd   <= '0;
      r_rollback    <= 1'b0;
      r_rollback_pc <= '0;
    end else begin
      r_commit   <= w_commit;
      r_rollback <= w_mispredict;
      if (w_commit) begin
        r_commit_rf   <= r_has_rd[r_head];
        r_commit_pc   <= r_pc[r_head];
        r_commit_tag  <= r_head;
        r_commit_data <= r_data[r_head];
        r_commit_rd   <= r_rd[r_head];
      end else begin
        r_commit_rf   <= 1'b0;
        r_commit_pc   <= '0;
        r_commit_tag  <= '0;
        r_commit_data <= '0;
        r_commit_rd   <= '0;
      end
      r_rollback_pc <= w_mispredict ? r_target[r_head] : 32'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Operand queries. A same-cycle CDB broadcast for a busy entry is forwarded
  // so dispatch does not miss a result that lands while it is looking.
  // ---------------------------------------------------------------------------
  logic [1:0][TAG_W-1:0] w_q_tag;
  logic [1:0]            w_q_ready;
  logic [1:0][31:0]      w_q_data;

  assign w_q_tag = {q2_tag_in, q1_tag_in};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_query
      logic        w_rdy;
      logic [31:0] w_dat;

      always_comb begin
        w_rdy = 1'b0;
        w_dat = '0;
        if (w_q_tag[gi] != '0 && r_busy[w_q_tag[gi]]) begin
          if (cdb_valid_in && (cdb_tag_in == w_q_tag[gi])) begin
            w_rdy = 1'b1;
            w_dat = cdb_data_in;
          end else if (r_ready[w_q_tag[gi]]) begin
            w_rdy = 1'b1;
            w_dat = r_data[w_q_tag[gi]];
          end
        end
      end

      assign w_q_ready[gi] = w_rdy;
      assign w_q_data[gi]  = w_dat;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Output wiring
  // ---------------------------------------------------------------------------
  assign rob_next_tag_out     = r_tail;
  assign rob_full_out         = w_full;
  assign q1_ready_out         = w_q_ready[0];
  assign q2_ready_out         = w_q_ready[1];
  assign q1_data_out          = w_q_data[0];
  assign q2_data_out          = w_q_data[1];
  assign commit_signal_out    = r_commit;
  assign commit_rf_signal_out = r_commit_rf;
  assign commit_pc_out        = r_commit_pc;
  assign commit_tag_out       = r_commit_tag;
  assign commit_data_out      = r_commit_data;
  assign commit_target_out    = r_commit_rd;
  assign rollback_out         = r_rollback;
  assign rollback_pc_out      = r_rollback_pc;

endmodule
